// File: rtl/z80_pin_if.sv
// Control and address signals between the CPU bus/control logic and the pin latches.
// The tri-state pins travel as plain wires on the pin-interface ports.
interface z80_pin_if #(
    parameter int AW = 16
);
    logic [AW-1:0] address;
    logic          bus_ab_pin_we;
    logic          pin_control_oe;
    logic          ctl_bus_db_we;
    logic          bus_db_pin_re;
    logic          bus_db_pin_oe;
    logic          ctl_bus_db_oe;

    modport master (
        output address, bus_ab_pin_we, pin_control_oe,
        output ctl_bus_db_we, bus_db_pin_re, bus_db_pin_oe, ctl_bus_db_oe
    );

    modport slave (
        input address, bus_ab_pin_we, pin_control_oe,
        input ctl_bus_db_we, bus_db_pin_re, bus_db_pin_oe, ctl_bus_db_oe
    );
endinterface

// File: rtl/z80_pin_interface.sv
// Z80 pin interface: registered address-pin latch and bidirectional data-pin latch,
// each driving its buses through independent tri-state enables.
module z80_pin_interface #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    z80_pin_if.slave      ctl,
    output wire  [AW-1:0] abus,
    inout  wire  [DW-1:0] db,
    inout  wire  [DW-1:0] D
);
    logic [AW-1:0] ab_q, ab_d;
    logic [DW-1:0] dl_q, dl_d;

    always_comb begin
        ab_d = ab_q;
        if (ctl.bus_ab_pin_we) ab_d = ctl.address;
    end

    // The internal-bus write outranks the pin read when both strobe together.
    always_comb begin
        dl_d = dl_q;
        if (ctl.ctl_bus_db_we)      dl_d = db;
        else if (ctl.bus_db_pin_re) dl_d = D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ab_q <= '0;
            dl_q <= '0;
        end else begin
            ab_q <= ab_d;
            dl_q <= dl_d;
        end
    end

    assign abus = ctl.pin_control_oe ? ab_q : {AW{1'bz}};
    assign D    = ctl.bus_db_pin_oe  ? dl_q : {DW{1'bz}};
    assign db   = ctl.ctl_bus_db_oe  ? dl_q : {DW{1'bz}};
endmodule

// File: tb/tb_z80_pin_interface.sv
// Directed bench for z80_pin_interface; expected bus values are queued as stimulus
// is applied and popped when the pins are observed.
module tb_z80_pin_interface;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z80_pin_if #(.AW(AW)) cif ();

    wire [AW-1:0] abus;
    wire [DW-1:0] db;
    wire [DW-1:0] D;

    logic          tb_db_oe, tb_d_oe;
    logic [DW-1:0] tb_db, tb_d;
    assign db = tb_db_oe ? tb_db : {DW{1'bz}};
    assign D  = tb_d_oe  ? tb_d  : {DW{1'bz}};

    // Weak pull-ups make a released (high-Z) bus read back as all ones.
    for (genvar i = 0; i < AW; i++) begin : g_pu_ab
        pullup (abus[i]);
    end
    for (genvar i = 0; i < DW; i++) begin : g_pu_d
        pullup (D[i]);
        pullup (db[i]);
    end

    z80_pin_interface #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (cif.slave),
        .abus  (abus),
        .db    (db),
        .D     (D)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        cif.address = '0;        cif.bus_ab_pin_we = 1'b0; cif.pin_control_oe = 1'b0;
        cif.ctl_bus_db_we = 1'b0; cif.bus_db_pin_re = 1'b0;
        cif.bus_db_pin_oe = 1'b0; cif.ctl_bus_db_oe = 1'b0;
        tb_db_oe = 1'b0; tb_d_oe = 1'b0; tb_db = '0; tb_d = '0;

        // Reset with drivers enabled: latches read back as zero
        @(negedge clk);
        cif.pin_control_oe = 1'b1; cif.bus_db_pin_oe = 1'b1; cif.ctl_bus_db_oe = 1'b1;
        push("rst_abus", 16'h0000); push("rst_D", 16'h0000); push("rst_db", 16'h0000);
        #1; check(abus); check({8'h00, D}); check({8'h00, db});
        cif.pin_control_oe = 1'b0; cif.bus_db_pin_oe = 1'b0; cif.ctl_bus_db_oe = 1'b0;
        push("rst_abus_z", 16'hFFFF); push("rst_D_z", 16'h00FF);
        #1; check(abus); check({8'h00, D});

        // Address capture: old value visible until the edge
        @(negedge clk);
        reset = 1'b0;
        cif.address = 16'hAA55; cif.bus_ab_pin_we = 1'b1; cif.pin_control_oe = 1'b1;
        push("ab_before_edge", 16'h0000);
        #1; check(abus);
        @(negedge clk);
        cif.bus_ab_pin_we = 1'b0;
        push("ab_capture", 16'hAA55);
        #1; check(abus);

        // Address hold across OE toggles and address changes
        cif.address = 16'h1234; cif.pin_control_oe = 1'b0;
        push("ab_oe_off", 16'hFFFF);
        #1; check(abus);
        cif.pin_control_oe = 1'b1;
        push("ab_hold", 16'hAA55);
        #1; check(abus);
        @(negedge clk);
        push("ab_hold_edge", 16'hAA55);
        #1; check(abus);
        cif.pin_control_oe = 1'b0;
        push("ab_release", 16'hFFFF);
        #1; check(abus);

        // Pin read, then internal write shows old value until the edge
        tb_d = 8'hAA; tb_d_oe = 1'b1; cif.bus_db_pin_re = 1'b1;
        @(negedge clk);
        cif.bus_db_pin_re = 1'b0; tb_d_oe = 1'b0; cif.bus_db_pin_oe = 1'b1;
        tb_db = 8'h55; tb_db_oe = 1'b1; cif.ctl_bus_db_we = 1'b1;
        push("pin_read", 16'h00AA);
        #1; check({8'h00, D});
        @(negedge clk);
        cif.ctl_bus_db_we = 1'b0; tb_db_oe = 1'b0;
        push("db_write", 16'h0055);
        #1; check({8'h00, D});
        @(negedge clk);
        push("dl_hold", 16'h0055);
        #1; check({8'h00, D});

        // Internal-bus output driver
        tb_db = 8'h3C; tb_db_oe = 1'b1; cif.ctl_bus_db_we = 1'b1; cif.bus_db_pin_oe = 1'b0;
        @(negedge clk);
        cif.ctl_bus_db_we = 1'b0; tb_db_oe = 1'b0; cif.ctl_bus_db_oe = 1'b1;
        push("db_drive", 16'h003C);
        #1; check({8'h00, db});
        cif.bus_db_pin_oe = 1'b1;
        push("both_oe_db", 16'h003C); push("both_oe_D", 16'h003C);
        #1; check({8'h00, db}); check({8'h00, D});
        cif.ctl_bus_db_oe = 1'b0; cif.bus_db_pin_oe = 1'b0;
        push("db_release", 16'h00FF);
        #1; check({8'h00, db});

        // Both write strobes: internal bus wins
        tb_db = 8'h11; tb_db_oe = 1'b1; tb_d = 8'h22; tb_d_oe = 1'b1;
        cif.ctl_bus_db_we = 1'b1; cif.bus_db_pin_re = 1'b1;
        @(negedge clk);
        cif.ctl_bus_db_we = 1'b0; cif.bus_db_pin_re = 1'b0;
        tb_db_oe = 1'b0; tb_d_oe = 1'b0; cif.bus_db_pin_oe = 1'b1;
        push("priority", 16'h0011);
        #1; check({8'h00, D});

        // Reset in mid-cycle clears both latches without a clock edge
        cif.pin_control_oe = 1'b1;
        #1 reset = 1'b1;
        push("async_rst_abus", 16'h0000); push("async_rst_D", 16'h0000);
        #1; check(abus); check({8'h00, D});
        reset = 1'b0;
        @(negedge clk);
        push("post_rst_abus", 16'h0000);
        #1; check(abus);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
